gpio_key_arbiter: RTL



---
 rtl/gpio_key_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gpio_key_arbiter.sv
// Shares a one-bit GPIO PIO slave between the HPS bridge and a debounced push-button.
// Each accepted press toggles the bit; an HPS write to address 0 sets it directly.
module gpio_key_arbiter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_n,
    input  logic [1:0]  hps_address,
    input  logic        hps_chipselect,
    input  logic        hps_write_n,
    input  logic [31:0] hps_writedata,
    output logic [31:0] hps_readdata,
    output logic        hps_waitrequest,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        key_event
);
    typedef enum logic [1:0] {IDLE, GRANT_HPS, GRANT_KEY} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_sync_p0;
    logic             key_sync_p1;
    logic             key_db;
    logic [CNT_W-1:0] db_cnt;
    logic             press;
    logic             shadow;
    logic             key_pending;
    logic             key_overrun;
    logic             last_grant_hps;
    logic             hps_req;
    logic             load_pio_hps;
    logic             load_pio_key;
    state_t           state;
    state_t           state_nxt;

    // Stage p0/p1: two-flop synchronizer, then the debounce counter on the synced level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_sync_p0 <= 1'b1;
            key_sync_p1 <= 1'b1;
            key_db      <= 1'b1;
            db_cnt      <= '0;
        end else begin
            key_sync_p0 <= key_n;
            key_sync_p1 <= key_sync_p0;
            if (key_sync_p1 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_MAX) begin
                key_db <= key_sync_p1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    assign press   = key_db && !key_sync_p1 && (db_cnt == CNT_MAX);
    assign hps_req = hps_chipselect && !hps_write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hps_req && key_pending) begin
                    state_nxt = last_grant_hps ? GRANT_KEY : GRANT_HPS;
                end else if (hps_req) begin
                    state_nxt = GRANT_HPS;
                end else if (key_pending) begin
                    state_nxt = GRANT_KEY;
                end
            end
            GRANT_HPS: state_nxt = IDLE;
            GRANT_KEY: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hps_waitrequest = hps_req && (state != GRANT_HPS);
        load_pio_hps    = (state_nxt == GRANT_HPS) && (hps_address == 2'd0);
        load_pio_key    = (state_nxt == GRANT_KEY);
        case (hps_address)
            2'd0:    hps_readdata = {31'b0, shadow};
            2'd1:    hps_readdata = {30'b0, key_overrun, key_pending};
            default: hps_readdata = 32'b0;
        endcase
    end

    // PIO master registers load on entry to a grant so the write occupies exactly the grant cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            pio_chipselect <= load_pio_hps || load_pio_key;
            pio_write_n    <= !(load_pio_hps || load_pio_key);
            if (load_pio_hps) begin
                pio_writedata <= hps_writedata;
            end else if (load_pio_key) begin
                pio_writedata <= {31'b0, ~shadow};
            end
        end
    end

    assign pio_address = 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow         <= 1'b0;
            key_pending    <= 1'b0;
            key_overrun    <= 1'b0;
            key_event      <= 1'b0;
            last_grant_hps <= 1'b0;
        end else begin
            key_event <= press;
            if (state == GRANT_HPS) begin
                last_grant_hps <= 1'b1;
                if (hps_address == 2'd0) begin
                    shadow <= hps_writedata[0];
                end
                if ((hps_address == 2'd1) && hps_writedata[1]) begin
                    key_overrun <= 1'b0;
                end
            end
            if (state == GRANT_KEY) begin
                last_grant_hps <= 1'b0;
                shadow         <= ~shadow;
            end
            // A press coinciding with the key grant re-arms pending instead of counting as overrun
            if (press) begin
                key_pending <= 1'b1;
                if (key_pending && (state != GRANT_KEY)) begin
                    key_overrun <= 1'b1;
                end
            end else if (state == GRANT_KEY) begin
                key_pending <= 1'b0;
            end
        end
    end

endmodule
